std_sram_sp_ctrl: RTL and testbench

STD_SRAM_SP_CTRL -- requirements
Module: std_sram_sp_ctrl

---
 rtl/std_sram_sp_ctrl_if.sv | 32 +++
 rtl/std_sram_sp_ctrl.sv | 110 +++++++++++
 tb/tb_std_sram_sp_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/std_sram_sp_ctrl_if.sv
// Request/response handshake and SRAM macro pins of the single-port SRAM controller.
interface std_sram_sp_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 1,
    parameter int unsigned DATA_WIDTH = 1
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_din;
    logic                  clr;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_dout;
    logic                  init_done;
    logic                  sram_en;
    logic                  sram_we;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_din;
    logic [DATA_WIDTH-1:0] sram_dout;

    // Environment side: requester, response consumer and the SRAM macro itself.
    modport master (
        output req_valid, req_we, req_addr, req_din, clr, rsp_ready, sram_dout,
        input  req_ready, rsp_valid, rsp_dout, init_done, sram_en, sram_we, sram_addr, sram_din
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_din, clr, rsp_ready, sram_dout,
        output req_ready, rsp_valid, rsp_dout, init_done, sram_en, sram_we, sram_addr, sram_din
    );
endinterface

// File: rtl/std_sram_sp_ctrl.sv
// Single-port SRAM controller: zero-fills the array after reset or clr, then
// serves one read or write per cycle with a one-entry registered read response.
module std_sram_sp_ctrl #(
    parameter int unsigned ADDR_WIDTH = 1,
    parameter int unsigned DATA_WIDTH = 1
) (
    input  logic              clk,
    input  logic              reset,
    std_sram_sp_ctrl_if.slave bus
);
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_dout_q, rsp_dout_d;

    logic                  run;
    logic                  req_ready_c;
    logic                  accept;
    logic                  rd_accept;
    logic                  sram_en_c;
    logic                  sram_we_c;
    logic [ADDR_WIDTH-1:0] sram_addr_c;
    logic [DATA_WIDTH-1:0] sram_din_c;

    // clr wins over a pending request, so it also withdraws req_ready.
    assign run         = (state_q == RUN);
    assign req_ready_c = run & ~bus.clr & (~rsp_valid_q | bus.rsp_ready);
    assign accept      = req_ready_c & bus.req_valid;
    assign rd_accept   = accept & ~bus.req_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dout_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dout_q  <= rsp_dout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dout_d  = rsp_dout_q;

        case (state_q)
            INIT: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.clr) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = INIT;
        endcase

        // The response register keeps draining during a fill.
        if (rd_accept) begin
            rsp_valid_d = 1'b1;
            rsp_dout_d  = bus.sram_dout;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_comb begin
        sram_en_c   = 1'b0;
        sram_we_c   = 1'b0;
        sram_addr_c = bus.req_addr;
        sram_din_c  = bus.req_din;

        case (state_q)
            INIT: begin
                sram_en_c   = 1'b1;
                sram_we_c   = 1'b1;
                sram_addr_c = cnt_q;
                sram_din_c  = '0;
            end
            RUN: begin
                sram_en_c = accept;
                sram_we_c = accept & bus.req_we;
            end
            default: ;
        endcase
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dout  = rsp_dout_q;
    assign bus.init_done = run;
    assign bus.sram_en   = sram_en_c;
    assign bus.sram_we   = sram_we_c;
    assign bus.sram_addr = sram_addr_c;
    assign bus.sram_din  = sram_din_c;
endmodule

// File: tb/tb_std_sram_sp_ctrl.sv
// Bench for std_sram_sp_ctrl: directed scenarios plus random traffic, all checked
// every cycle against a memory-array/response-slot model of the controller.
module tb_std_sram_sp_ctrl;
    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    std_sram_sp_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    std_sram_sp_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // SRAM macro: combinational read, write on the rising edge.
    logic [DW-1:0] mem [DEPTH];
    assign bus.sram_dout = mem[bus.sram_addr];
    always @(posedge clk) begin
        if (bus.sram_en && bus.sram_we) mem[bus.sram_addr] <= bus.sram_din;
    end

    // Model: cycles of fill left (0 = serving requests), expected contents, response slot.
    int            fill_left;
    logic [DW-1:0] m_mem [DEPTH];
    logic          m_rv;
    logic [DW-1:0] m_rd;

    logic          s_init_done, s_req_ready, s_rsp_valid, s_en, s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_din, s_rsp_dout;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        fill_left = DEPTH;
        m_rv      = 1'b0;
        m_rd      = '0;
    endtask

    // One clock: drive at the falling edge, compare 1 time unit later, advance model at the rising edge.
    task automatic cycle(input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic rr, input logic c, input logic r);
        logic          running, e_ready, e_acc, e_en, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_din   = d;
        bus.rsp_ready = rr;
        bus.clr       = c;
        reset         = r;
        if (r) model_reset();
        #1;
        running = (fill_left == 0);
        e_ready = running && !c && (!m_rv || rr);
        e_acc   = e_ready && v;
        if (running) begin
            e_en = e_acc; e_we = e_acc && we; e_addr = a; e_din = d;
        end else begin
            e_en = 1'b1; e_we = 1'b1; e_addr = AW'(DEPTH - fill_left); e_din = '0;
        end
        s_init_done = bus.init_done; s_req_ready = bus.req_ready;
        s_rsp_valid = bus.rsp_valid; s_rsp_dout  = bus.rsp_dout;
        s_en = bus.sram_en; s_we = bus.sram_we; s_addr = bus.sram_addr; s_din = bus.sram_din;
        chk("init_done", 32'(s_init_done), 32'(running));
        chk("req_ready", 32'(s_req_ready), 32'(e_ready));
        chk("rsp_valid", 32'(s_rsp_valid), 32'(m_rv));
        chk("rsp_dout",  32'(s_rsp_dout),  32'(m_rd));
        chk("sram_en",   32'(s_en),        32'(e_en));
        chk("sram_we",   32'(s_we),        32'(e_we));
        chk("sram_addr", 32'(s_addr),      32'(e_addr));
        chk("sram_din",  32'(s_din),       32'(e_din));
        @(posedge clk);
        if (!r) begin
            if (e_acc && !we) begin
                m_rv = 1'b1;
                m_rd = m_mem[a];
            end else if (m_rv && rr) begin
                m_rv = 1'b0;
            end
            if (!running) begin
                m_mem[e_addr] = '0;
                fill_left--;
            end else if (e_acc && we) begin
                m_mem[a] = d;
            end else if (c) begin
                fill_left = DEPTH;
            end
        end
    endtask

    task automatic idle(input logic rr);
        cycle(1'b0, 1'b0, '0, '0, rr, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_din = '0;
        bus.rsp_ready = 1'b0; bus.clr = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i]   = DW'($urandom);
            m_mem[i] = mem[i];
        end
        model_reset();

        cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("lit_reset_init_done", 32'(s_init_done), 32'd0);
        chk("lit_reset_rsp_valid", 32'(s_rsp_valid), 32'd0);
        chk("lit_reset_rsp_dout",  32'(s_rsp_dout),  32'd0);

        // Power-up fill: one zero write per address, then serving on cycle 17.
        for (int i = 0; i < 16; i++) begin
            idle(1'b0);
            chk("lit_fill_we",   32'(s_we),   32'd1);
            chk("lit_fill_addr", 32'(s_addr), 32'(i));
            chk("lit_fill_din",  32'(s_din),  32'd0);
            chk("lit_fill_busy", 32'(s_init_done), 32'd0);
        end
        idle(1'b0);
        chk("lit_init_done_17", 32'(s_init_done), 32'd1);

        // Write then read-back, back-to-back reads.
        cycle(1'b1, 1'b1, 4'd3, 8'hA5, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 4'd4, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("lit_rd3_valid", 32'(s_rsp_valid), 32'd1);
        chk("lit_rd3_dout",  32'(s_rsp_dout),  32'hA5);
        chk("lit_b2b_ready", 32'(s_req_ready), 32'd1);
        idle(1'b1);
        chk("lit_rd4_dout",  32'(s_rsp_dout),  32'h00);
        chk("lit_rd4_valid", 32'(s_rsp_valid), 32'd1);
        idle(1'b1);
        chk("lit_drained", 32'(s_rsp_valid), 32'd0);

        // Backpressure holds the response and stalls requests.
        cycle(1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 4'd5, 8'h00, 1'b0, 1'b0, 1'b0);
            chk("lit_stall_ready", 32'(s_req_ready), 32'd0);
            chk("lit_stall_dout",  32'(s_rsp_dout),  32'hA5);
        end
        idle(1'b1);
        chk("lit_pop_valid", 32'(s_rsp_valid), 32'd1);
        idle(1'b0);
        chk("lit_popped", 32'(s_rsp_valid), 32'd0);

        // clr with a pending response; response drains during the fill.
        cycle(1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 4'd3, 8'hFF, 1'b0, 1'b1, 1'b0);
        chk("lit_clr_ready", 32'(s_req_ready), 32'd0);
        for (int i = 0; i < 16; i++) begin
            idle(i == 5);
            chk("lit_clr_busy", 32'(s_init_done), 32'd0);
            chk("lit_clr_pending", 32'(s_rsp_valid), 32'(i <= 5));
        end
        idle(1'b1);
        chk("lit_clr_done", 32'(s_init_done), 32'd1);
        cycle(1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        chk("lit_clr_zeroed", 32'(s_rsp_dout), 32'h00);

        // Reset at fill address 7 aborts the fill and a pending response.
        cycle(1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) idle(1'b0);
        chk("lit_pre_abort_addr", 32'(s_addr), 32'd6);
        cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("lit_abort_valid", 32'(s_rsp_valid), 32'd0);
        chk("lit_abort_done",  32'(s_init_done), 32'd0);
        idle(1'b0);
        chk("lit_restart_addr", 32'(s_addr), 32'd0);
        chk("lit_restart_we",   32'(s_we),   32'd1);

        // Random traffic with occasional clr and reset.
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), AW'($urandom),
                  DW'($urandom), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 499) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
